// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared constants and FSM encoding for the Viterbi frame controller
package viterbi_pkg;
  localparam int STATE_W = 6;
  localparam int K = 7;
  localparam int TAIL = 6;
  localparam int MAX_LENGTH = 192;
  localparam int ACS_LATENCY = 2;
  localparam int LEN_W = 10;
  localparam logic [K-1:0] UNKNOWN_STATE = 7'b1000000;
  typedef enum logic [2:0] {IDLE, ACS, FLUSH, TRACEBACK, OUTPUT} fsm_t;
endpackage

// File: rtl/viterbi_frame_controller_if.sv
// viterbi_frame_controller_if: frame, ACS, survivor-memory and output signals of the controller
interface viterbi_frame_controller_if;
  import viterbi_pkg::*;
  logic frame_start;
  logic [LEN_W-1:0] frame_length;
  logic in_valid;
  logic in_ready;
  logic [1:0] in_bits;
  logic acs_init;
  logic acs_step;
  logic [1:0] acs_bits;
  logic [LEN_W-1:0] surv_wr_addr;
  logic surv_rd_en;
  logic [LEN_W-1:0] surv_rd_addr;
  logic [STATE_W-1:0] surv_rd_state;
  logic surv_decision;
  logic out_valid;
  logic out_ready;
  logic out_bit;
  logic out_last;
  logic busy;
  logic error;
  modport master (
    output frame_start, frame_length, in_valid, in_bits, surv_decision, out_ready,
    input in_ready, acs_init, acs_step, acs_bits, surv_wr_addr, surv_rd_en, surv_rd_addr,
    surv_rd_state, out_valid, out_bit, out_last, busy, error
  );
  modport slave (
    input frame_start, frame_length, in_valid, in_bits, surv_decision, out_ready,
    output in_ready, acs_init, acs_step, acs_bits, surv_wr_addr, surv_rd_en, surv_rd_addr,
    surv_rd_state, out_valid, out_bit, out_last, busy, error
  );
endinterface

// File: rtl/viterbi_bit_lifo.sv
// viterbi_bit_lifo: shift-register bit stack; top is always bits[0]
module viterbi_bit_lifo #(
  parameter int DEPTH = 186,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic top,
  output logic empty,
  output logic [CW-1:0] count
);
  logic [DEPTH-1:0] bits;
  // push shifts toward the MSB end, pop shifts back so the newest bit sits at bit 0
  always_ff @(posedge clk)
    if (rst) begin
      bits <= '0;
      count <= '0;
    end else if (push && !pop) begin
      bits <= {bits[DEPTH-2:0], din};
      count <= count + CW'(1);
    end else if (pop && !push) begin
      bits <= {1'b0, bits[DEPTH-1:1]};
      count <= count - CW'(1);
    end
  assign top = bits[0];
  assign empty = count == '0;
endmodule

// File: rtl/viterbi_frame_controller.sv
// viterbi_frame_controller: sequences one frame through ACS steps, survivor traceback and bit output
module viterbi_frame_controller
  import viterbi_pkg::*;
(
  input logic clk,
  input logic rst,
  viterbi_frame_controller_if.slave bus
);
  localparam int CW = $clog2(MAX_LENGTH - TAIL + 1);
  fsm_t state, state_n;
  logic [LEN_W-1:0] n, cnt, t;
  logic [STATE_W-1:0] s;
  logic phase, len_ok, start, in_hs, push, pop, empty, top;
  logic [CW-1:0] count;
  assign len_ok = bus.frame_length > LEN_W'(TAIL) && bus.frame_length <= LEN_W'(MAX_LENGTH);
  assign start = state == IDLE && bus.frame_start && len_ok;
  assign bus.in_ready = state == ACS;
  assign in_hs = bus.in_valid && bus.in_ready;
  assign bus.surv_rd_en = state == TRACEBACK && !phase;
  assign bus.surv_rd_addr = t;
  assign bus.surv_rd_state = s;
  assign push = state == TRACEBACK && phase && t < n - LEN_W'(TAIL);
  assign bus.out_valid = state == OUTPUT && !empty;
  assign pop = bus.out_valid && bus.out_ready;
  assign bus.out_bit = top;
  assign bus.out_last = bus.out_valid && count == CW'(1);
  assign bus.busy = state != IDLE;
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  // next state: frame start, N accepted symbols, flush wait, 2N traceback cycles, drain LIFO
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (start) state_n = ACS;
      ACS:       if (in_hs && cnt == n - LEN_W'(1)) state_n = FLUSH;
      FLUSH:     if (cnt == LEN_W'(ACS_LATENCY - 1)) state_n = TRACEBACK;
      TRACEBACK: if (phase && t == '0) state_n = OUTPUT;
      OUTPUT:    if (pop && count == CW'(1)) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end
  // datapath: length latch, ACS step registers, flush counter, traceback index and state
  always_ff @(posedge clk)
    if (rst) begin
      n <= '0;
      cnt <= '0;
      t <= '0;
      s <= '0;
      phase <= 1'b0;
      bus.acs_init <= 1'b0;
      bus.acs_step <= 1'b0;
      bus.acs_bits <= '0;
      bus.surv_wr_addr <= '0;
      bus.error <= 1'b0;
    end else begin
      bus.acs_init <= start;
      bus.error <= state == IDLE && bus.frame_start && !len_ok;
      bus.acs_step <= in_hs;
      if (start) begin
        n <= bus.frame_length;
        cnt <= '0;
      end
      if (in_hs) begin
        bus.acs_bits <= bus.in_bits;
        bus.surv_wr_addr <= cnt;
        cnt <= cnt == n - LEN_W'(1) ? '0 : cnt + LEN_W'(1);
      end
      if (state == FLUSH) begin
        cnt <= cnt + LEN_W'(1);
        t <= n - LEN_W'(1);
        s <= '0;
        phase <= 1'b0;
      end
      if (state == TRACEBACK) begin
        phase <= !phase;
        if (phase) begin
          s <= {s[STATE_W-2:0], bus.surv_decision};
          t <= t == '0 ? t : t - LEN_W'(1);
        end
      end
    end
  viterbi_bit_lifo #(.DEPTH(MAX_LENGTH - TAIL), .CW(CW)) u_lifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .din(s[STATE_W-1]),
    .top(top),
    .empty(empty),
    .count(count)
  );
endmodule

// File: tb/tb_viterbi_frame_controller.sv
// tb_viterbi_frame_controller: scoreboard bench with a message-level survivor/decoder model
module tb_viterbi_frame_controller;
  import viterbi_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  viterbi_frame_controller_if bus();
  viterbi_frame_controller dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0, errors = 0, cyc = 0;
  bit u[0:1023];
  bit written[0:1023];
  int wr_cyc[0:1023];
  logic [1:0] in_q[$];
  int idx_q[$];
  bit out_q[$];
  int n_hs, n_step, n_init, n_err, n_rd, exp_t, init_cyc, step_cyc, rd_cyc, out_cyc;
  bit pend_d = 1'b0;
  logic prev_ov = 1'b0, prev_or = 1'b0, prev_ob = 1'b0, prev_ol = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // encoder state after input bit t: newest bit in the MSB, zeros before the frame
  function automatic logic [5:0] true_state(input int t);
    logic [5:0] st;
    st = '0;
    for (int i = 0; i < 6; i++) st[5-i] = (t >= i) ? u[t-i] : 1'b0;
    return st;
  endfunction

  always @(posedge clk) cyc++;
  always @(posedge clk) bus.surv_decision <= pend_d;

  // monitor: ACS scoreboard, survivor memory model, output scoreboard
  always @(negedge clk) begin
    if (rst) begin
      pend_d = 1'b0;
      prev_ov = 1'b0;
    end else begin
      if (bus.acs_init) begin n_init++; init_cyc = cyc; end
      if (bus.error) n_err++;
      if (bus.acs_step) begin
        if (in_q.size() == 0) chk("acs_step without symbol", 1, 0);
        else begin
          chk("acs_bits", bus.acs_bits, in_q.pop_front());
          chk("surv_wr_addr", bus.surv_wr_addr, idx_q.pop_front());
        end
        if (n_step == 0) step_cyc = cyc;
        n_step++;
        written[bus.surv_wr_addr] = 1'b1;
        wr_cyc[bus.surv_wr_addr] = cyc;
      end
      if (bus.in_valid && bus.in_ready) begin
        in_q.push_back(bus.in_bits);
        idx_q.push_back(n_hs);
        n_hs++;
      end
      pend_d = 1'b0;
      if (bus.surv_rd_en) begin
        if (n_rd == 0) rd_cyc = cyc;
        n_rd++;
        chk("surv_rd_addr", bus.surv_rd_addr, exp_t);
        chk("surv_rd_state", bus.surv_rd_state, true_state(exp_t));
        chk("survivor written before read", written[bus.surv_rd_addr], 1);
        chk("survivor read after latency", int'(cyc - wr_cyc[bus.surv_rd_addr] >= ACS_LATENCY), 1);
        if (bus.surv_rd_state == true_state(int'(bus.surv_rd_addr)))
          pend_d = int'(bus.surv_rd_addr) >= 6 ? u[int'(bus.surv_rd_addr) - 6] : 1'b0;
        else
          pend_d = 1'($urandom % 2);
        exp_t--;
      end
      if (prev_ov && !prev_or) begin
        chk("out_valid held", bus.out_valid, 1);
        chk("out_bit held", bus.out_bit, prev_ob);
        chk("out_last held", bus.out_last, prev_ol);
      end
      if (bus.out_valid && !bus.busy) chk("busy with out_valid", 0, 1);
      if (prev_ov && !bus.out_valid) chk("busy falls with out_valid", bus.busy, 0);
      if (bus.out_valid && out_cyc < 0) out_cyc = cyc;
      if (bus.out_valid && bus.out_ready) begin
        if (out_q.size() == 0) chk("unexpected out bit", 1, 0);
        else begin
          chk("out_bit", bus.out_bit, out_q.pop_front());
          chk("out_last", bus.out_last, int'(out_q.size() == 0));
        end
      end
      prev_ov = bus.out_valid;
      prev_or = bus.out_ready;
      prev_ob = bus.out_bit;
      prev_ol = bus.out_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string name);
    chk({name, " ctl"}, {bus.in_ready, bus.acs_init, bus.acs_step, bus.acs_bits, bus.surv_rd_en,
        bus.out_valid, bus.out_bit, bus.out_last, bus.busy, bus.error}, 0);
    chk({name, " addr"}, {bus.surv_wr_addr, bus.surv_rd_addr, bus.surv_rd_state}, 0);
  endtask

  // kind: 0 all-zero, 1 known message 10110010, 2 random message; tail bits always zero
  task automatic run_frame(input int n, input int kind, input bit toggle, input bit stall,
                           input bit fs_out, input int abort_t);
    logic [7:0] msg;
    int sent, c, pops, stall_left;
    bit fin, seen, stalled, aborted;
    msg = 8'b10110010;
    sent = 0; pops = 0; stall_left = 0; seen = 0; stalled = 0; aborted = 0;
    for (int i = 0; i < n; i++)
      u[i] = (i >= n - TAIL) ? 1'b0 : kind == 0 ? 1'b0 : kind == 1 ? msg[7-i] : 1'($urandom % 2);
    for (int i = 0; i < 1024; i++) written[i] = 1'b0;
    out_q.delete(); in_q.delete(); idx_q.delete();
    for (int i = 0; i < n - TAIL; i++) out_q.push_back(u[i]);
    n_hs = 0; n_step = 0; n_init = 0; n_err = 0; n_rd = 0; exp_t = n - 1;
    init_cyc = -1; step_cyc = -1; rd_cyc = -1; out_cyc = -1;
    bus.frame_length = 10'(n);
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    c = 0;
    while (sent < n && c < 4 * n + 20) begin
      bus.in_valid = !toggle || (c % 2 == 0);
      bus.in_bits = 2'($urandom);
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) sent++;
      tick();
      c++;
    end
    bus.in_valid = 1'b0;
    chk("symbols accepted", sent, n);
    c = 0;
    while ((bus.busy || out_q.size() != 0) && c < 8 * n + 100) begin
      @(negedge clk);
      if (c == 0) chk("in_ready drops", bus.in_ready, 0);
      fin = bus.out_valid && bus.out_ready && bus.out_last;
      seen |= bus.out_valid;
      if (bus.out_valid && bus.out_ready) pops++;
      if (stall && !stalled && pops == 3) begin stalled = 1; stall_left = 5; end
      if (abort_t >= 0 && bus.surv_rd_en && bus.surv_rd_addr == 10'(abort_t)) begin
        aborted = 1;
        break;
      end
      tick();
      bus.frame_start = fs_out && seen && !fin;
      if (stall_left > 0) begin
        bus.out_ready = 1'b0;
        stall_left--;
      end else bus.out_ready = stall ? 1'($urandom % 2) : 1'b1;
      c++;
    end
    bus.frame_start = 1'b0;
    bus.out_ready = 1'b1;
    if (abort_t >= 0) begin
      chk("reached abort point", aborted, 1);
      tick();
      rst = 1'b1;
      tick();
      @(negedge clk);
      chk_zero("outputs zero after mid-frame reset");
      tick();
      rst = 1'b0;
      out_q.delete(); in_q.delete(); idx_q.delete();
      repeat (4) @(negedge clk);
      chk("no output after abort", bus.out_valid, 0);
      chk("idle after abort", bus.busy, 0);
      tick();
      return;
    end
    chk("frame completes in time", int'(bus.busy || out_q.size() != 0), 0);
    chk("acs_step count", n_step, n);
    chk("acs_init count", n_init, 1);
    chk("acs_init precedes step 0", int'(init_cyc >= 0 && init_cyc < step_cyc), 1);
    chk("survivor reads", n_rd, n);
    chk("traceback cycles", out_cyc - rd_cyc, 2 * n);
    chk("error pulses", n_err, 0);
    chk("symbol queue drained", in_q.size(), 0);
    repeat (3) @(negedge clk);
    chk("stays idle after frame", bus.busy, 0);
    chk("no further acs_init", n_init, 1);
    tick();
  endtask

  task automatic bad_len(input int len);
    int e0, i0;
    e0 = n_err;
    i0 = n_init;
    bus.frame_length = 10'(len);
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    @(negedge clk);
    chk("error pulse", bus.error, 1);
    chk("busy after bad length", bus.busy, 0);
    @(negedge clk);
    chk("error single cycle", bus.error, 0);
    chk("busy stays low", bus.busy, 0);
    tick();
    chk("error count", n_err - e0, 1);
    chk("no acs_init on bad length", n_init - i0, 0);
  endtask

  initial begin
    bus.frame_start = 1'b0;
    bus.frame_length = '0;
    bus.in_valid = 1'b0;
    bus.in_bits = '0;
    bus.out_ready = 1'b1;
    n_hs = 0; n_step = 0; n_init = 0; n_err = 0; n_rd = 0; exp_t = 0;
    init_cyc = -1; step_cyc = -1; rd_cyc = -1; out_cyc = -1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset outputs");
    tick();
    rst = 1'b0;
    run_frame(24, 0, 0, 0, 0, -1);
    run_frame(14, 1, 0, 0, 0, -1);
    run_frame(40, 2, 1, 1, 0, -1);
    bad_len(6);
    bad_len(193);
    run_frame(24, 2, 0, 0, 0, 10);
    run_frame(24, 2, 1, 0, 0, -1);
    run_frame(30, 2, 0, 1, 1, -1);
    run_frame(7, 2, 1, 1, 0, -1);
    run_frame(192, 2, 1, 1, 0, -1);
    bad_len(0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/viterbi_frame_controller.md
Name: viterbi_frame_controller

Overview:
- Sequences one 802.11a frame through the Viterbi ACS unit and survivor memory.
- Accepts deinterleaved/depunctured bit pairs and issues one ACS step per pair.
- Then runs traceback from state 0 (tail-terminated) and emits decoded bits in forward order with valid/ready, dropping the TAIL bits.
- Sits between the depuncturer and the descrambler; the ACS/path-metric and survivor RAM are external.

Parameters:
MAX_LENGTH, 192, maximum symbols (bit pairs) per frame
TAIL, 6, trailing tail bits discarded from output
ACS_LATENCY, 2, cycles from AcsStep to the survivor write being readable

Ports:
Clock  input  1  system clock, all logic on rising edge
Reset  input  1  synchronous, active-high reset
FrameStart  input  1  pulse; latch FrameLength and begin a frame (IDLE only)
FrameLength  input  10  symbols in the frame, including TAIL
InValid  input  1  InBits valid
InReady  output  1  controller accepts InBits
InBits  input  2  {first, second} received coded bits
AcsInit  output  1  one-cycle pulse: ACS loads metric[0]=0, others max
AcsStep  output  1  one-cycle pulse: ACS processes AcsBits
AcsBits  output  2  registered copy of accepted InBits
SurvWrAddr  output  10  step index for the survivor write of this AcsStep
SurvRdEn  output  1  survivor read request
SurvRdAddr  output  10  step index to read
SurvRdState  output  6  state whose decision bit is requested
SurvDecision  input  1  decision bit, valid the cycle after SurvRdEn
OutValid  output  1  OutBit valid
OutReady  input  1  downstream accepts OutBit
OutBit  output  1  decoded bit
OutLast  output  1  marks last decoded bit of the frame
Busy  output  1  high in any state except IDLE
Error  output  1  one-cycle pulse: rejected FrameStart

Behaviour:
- Reset: FSM to IDLE. All outputs 0. Counters, LIFO pointer and latched length cleared. Reset mid-frame aborts the frame; no partial output is emitted afterwards.
- IDLE:
  - FrameStart with TAIL < FrameLength <= MAX_LENGTH: latch N=FrameLength, pulse AcsInit next cycle, go to ACS.
  - Out-of-range FrameLength: pulse Error next cycle, stay IDLE.
  - FrameStart outside IDLE is ignored (no Error).
- ACS:
  - InReady=1.
  - On handshake at cycle k, at k+1: AcsStep=1, AcsBits=InBits, SurvWrAddr=symbol index (0..N-1).
  - The first handshake may occur in the same cycle as the AcsInit pulse; AcsInit precedes step 0 by one cycle minimum.
  - After the N-th handshake, InReady drops in the next cycle; go to FLUSH.
- FLUSH: wait ACS_LATENCY cycles after the final AcsStep, then go to TRACEBACK with t=N-1, s=0.
- TRACEBACK: two-cycle substeps per symbol.
  - ISSUE: SurvRdEn=1, SurvRdAddr=t, SurvRdState=s.
  - CAPTURE: d=SurvDecision; decoded bit b=s[5].
    - If t < N-TAIL, push b into the LIFO.
    - s <= {s[4:0], d}.
    - If t==0, go to OUTPUT; else t <= t-1.
  - Duration is exactly 2N cycles.
- OUTPUT: LIFO pop order yields bit 0 first.
  - OutValid=1 while the LIFO is non-empty; OutBit=top.
  - Pop on OutValid&OutReady.
  - OutLast=1 with the final bit.
  - OutBit/OutLast are held stable while OutReady=0.
  - After the last pop go to IDLE; Busy falls the same cycle OutValid falls.
- Widths: t and counters 10 bits; no wrap, since N <= MAX_LENGTH is enforced. LIFO depth MAX_LENGTH-TAIL.
- Simultaneous FrameStart and last OutReady pop: FrameStart is ignored; Busy was high.

Decomposition:
- Shared package viterbi_pkg: STATE_W=6, K=7, TAIL, MAX_LENGTH, FSM encoding (IDLE, ACS, FLUSH, TRACEBACK, OUTPUT), and the unknown-state code 7'b1000000 reused by the ACS.
- One sub-module: viterbi_bit_lifo (push/pop/empty/count, depth parameter, synchronous reset).

Test Plan:
- All-zero frame: N=24, InBits=00 every symbol, bench survivor model returns SurvDecision=0 -> exactly 18 OutBits, all 0, OutLast on the 18th; AcsStep count=24; traceback lasts 48 cycles.
- Known message: bench encodes 10110010 followed by 6 zeros (N=14), and the survivor model stores the true predecessor bits -> OutBits 1,0,1,1,0,0,1,0 in order; SurvRdAddr runs 13..0; SurvRdState starts at 0.
- Backpressure: InValid toggling 1/0 during ACS, and OutReady low for 5 cycles mid-output -> no lost or duplicated symbols; OutBit stable while stalled.
- Bad length: FrameStart with FrameLength=6, then with 193 -> Error pulses once each, Busy stays 0, no AcsInit.
- Reset mid-TRACEBACK at t=10 (N=24) -> next cycle all outputs 0; a new N=24 frame then decodes correctly.
- FrameStart asserted during OUTPUT -> ignored, no Error; the frame completes normally.
